// File: rtl/types_pkg.sv
// Shared types for the RV64 fetch stage: address/word types, BTB entry layout
// and the 2-bit saturating counter helper.
package types_pkg;

    typedef logic [63:0] addr_t;
    typedef logic [31:0] word_t;
    typedef logic [61:0] tag_t;

    typedef struct packed {
        logic       valid;
        tag_t       tag;
        addr_t      target;
        logic [1:0] cnt;
    } btb_entry_t;

    localparam logic [1:0] CNT_WEAK_T  = 2'b10;
    localparam logic [1:0] CNT_WEAK_NT = 2'b01;
    localparam addr_t      ALIGN_MASK  = 64'h3;

    function automatic logic [1:0] cnt_step(input logic [1:0] cnt, input logic up);
        if (up) begin
            return (cnt == 2'b11) ? cnt : cnt + 2'd1;
        end
        return (cnt == 2'b00) ? cnt : cnt - 2'd1;
    endfunction

endpackage

// File: rtl/fetch_unit_btb.sv
// Direct-mapped branch target buffer with 2-bit counters; combinational lookup
// sees pre-write contents, training is written at the clock edge.
module btb
    import types_pkg::*;
#(
    parameter int BTB_ENTRIES = 16
) (
    input  logic  clk,
    input  logic  rst_n,
    input  addr_t lookup_pc,
    output logic  hit,
    output logic  taken,
    output addr_t target,
    input  logic  update_valid,
    input  addr_t update_pc,
    input  addr_t update_target,
    input  logic  update_taken
);

    localparam int IDX = $clog2(BTB_ENTRIES);

    btb_entry_t entries_q [BTB_ENTRIES];
    btb_entry_t entries_d [BTB_ENTRIES];

    logic [IDX-1:0] lk_idx;
    logic [IDX-1:0] up_idx;
    tag_t           lk_tag;
    tag_t           up_tag;
    btb_entry_t     lk_entry;
    btb_entry_t     up_entry;

    // Tags keep every PC bit above the index, zero-extended into a fixed-width field.
    function automatic tag_t tag_of(input addr_t a);
        return tag_t'(a >> (IDX + 2));
    endfunction

    assign lk_idx = lookup_pc[IDX+1:2];
    assign up_idx = update_pc[IDX+1:2];
    assign lk_tag = tag_of(lookup_pc);
    assign up_tag = tag_of(update_pc);

    always_comb begin
        lk_entry = entries_q[lk_idx];
        hit      = lk_entry.valid && (lk_entry.tag == lk_tag);
        taken    = hit && lk_entry.cnt[1];
        target   = lk_entry.target;
    end

    always_comb begin
        entries_d = entries_q;
        up_entry  = entries_q[up_idx];
        if (update_valid) begin
            if (up_entry.valid && (up_entry.tag == up_tag)) begin
                up_entry.cnt = cnt_step(up_entry.cnt, update_taken);
                if (update_taken) begin
                    up_entry.target = update_target;
                end
            end else if (update_taken) begin
                up_entry = '{valid: 1'b1, tag: up_tag, target: update_target, cnt: CNT_WEAK_T};
            end
        end
        entries_d[up_idx] = up_entry;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                entries_q[i] <= '{valid: 1'b0, tag: '0, target: '0, cnt: CNT_WEAK_NT};
            end
        end else begin
            entries_q <= entries_d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, next-PC selection and BTB prediction,
// feeding the IF/ID latch.
module fetch_unit
    import types_pkg::*;
#(
    parameter addr_t RESET_PC    = 64'h0,
    parameter int    BTB_ENTRIES = 16
) (
    input  logic  CLK,
    input  logic  nRST,
    input  logic  ihit,
    input  word_t imem_instr,
    input  logic  freeze,
    input  logic  redirect_valid,
    input  addr_t redirect_pc,
    input  logic  update_valid,
    input  addr_t update_pc,
    input  addr_t update_target,
    input  logic  update_taken,
    output logic  imem_ren,
    output addr_t imem_addr,
    output word_t instr_if,
    output addr_t pc_if,
    output logic  pred_taken_if,
    output logic  flush
);

    addr_t pc_q;
    addr_t pc_d;
    logic  btb_hit;
    logic  btb_taken;
    addr_t btb_target;

    btb #(
        .BTB_ENTRIES(BTB_ENTRIES)
    ) u_btb (
        .clk          (CLK),
        .rst_n        (nRST),
        .lookup_pc    (pc_q),
        .hit          (btb_hit),
        .taken        (btb_taken),
        .target       (btb_target),
        .update_valid (update_valid),
        .update_pc    (update_pc),
        .update_target(update_target),
        .update_taken (update_taken)
    );

    assign pred_taken_if = btb_hit && btb_taken;
    assign imem_ren      = nRST;
    assign imem_addr     = pc_q;
    assign pc_if         = pc_q;
    assign instr_if      = imem_instr;
    assign flush         = redirect_valid;

    // A mispredict redirect beats stalls: the wrong path must be abandoned regardless.
    always_comb begin
        pc_d = pc_q + 64'd4;
        if (redirect_valid) begin
            pc_d = redirect_pc & ~ALIGN_MASK;
        end else if (freeze || !ihit) begin
            pc_d = pc_q;
        end else if (pred_taken_if) begin
            pc_d = btb_target;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule
